// File: rtl/qeciphy_rx_align_ctrl.sv
// Supervisory controller for the RX frame-alignment path: drives the boundary generator enable,
// watches lock and FAW integrity, forces realigns and latches a fault. Optional: QECIPHY_RX_ALIGN_STATS_EN.

package qeciphy_pkg;
    localparam logic [63:0] FAW_WORD = 64'hF628_F628_F628_F628;

    function automatic logic is_faw(input logic [63:0] data);
        return data == FAW_WORD;
    endfunction
endpackage

module qeciphy_rx_align_ctrl #(
    parameter int unsigned LOCK_TIMEOUT   = 2048,
    parameter int unsigned BAD_FAW_LIMIT  = 4,
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        link_ready_i,
    input  logic        clear_fault_i,
    input  logic [63:0] tdata_i,
    input  logic        locked_i,
    input  logic        faw_boundary_i,
    output logic        enable_o,
    output logic        aligned_o,
    output logic        fault_o,
    output logic [3:0]  retry_count_o,
    output logic [7:0]  realign_count_o
`ifdef QECIPHY_RX_ALIGN_STATS_EN
    ,
    output logic [15:0] bad_faw_total_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        HOLDOFF,
        SEARCH,
        MONITOR,
        FAULT
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]  HOLDOFF_LAST = 8'(HOLDOFF_CYCLES - 1);
    localparam logic [3:0]  BAD_LIMIT    = 4'(BAD_FAW_LIMIT);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t      state_reg;
    logic [15:0] timeout_cnt_reg;
    logic [7:0]  holdoff_cnt_reg;
    logic [3:0]  bad_cnt_reg;

    logic       faw_bad;
    logic [3:0] bad_inc;
    logic [3:0] retry_inc;

    assign faw_bad   = faw_boundary_i && !qeciphy_pkg::is_faw(tdata_i);
    assign bad_inc   = bad_cnt_reg + 4'd1;
    assign retry_inc = retry_count_o + 4'd1;

    // Outputs are assigned together with the state they belong to, so enable_o/aligned_o/fault_o
    // always reflect the state register of the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            timeout_cnt_reg <= '0;
            holdoff_cnt_reg <= '0;
            bad_cnt_reg     <= '0;
            enable_o        <= 1'b0;
            aligned_o       <= 1'b0;
            fault_o         <= 1'b0;
            retry_count_o   <= '0;
            realign_count_o <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (link_ready_i) begin
                        state_reg       <= HOLDOFF;
                        holdoff_cnt_reg <= '0;
                    end
                end
                HOLDOFF: begin
                    if (!link_ready_i) begin
                        state_reg <= IDLE;
                    end else if (holdoff_cnt_reg == HOLDOFF_LAST) begin
                        state_reg       <= SEARCH;
                        timeout_cnt_reg <= '0;
                        enable_o        <= 1'b1;
                    end else begin
                        holdoff_cnt_reg <= holdoff_cnt_reg + 8'd1;
                    end
                end
                SEARCH: begin
                    if (!link_ready_i) begin
                        state_reg <= IDLE;
                        enable_o  <= 1'b0;
                    end else if (locked_i) begin
                        state_reg     <= MONITOR;
                        aligned_o     <= 1'b1;
                        retry_count_o <= '0;
                        bad_cnt_reg   <= '0;
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        retry_count_o <= retry_inc;
                        enable_o      <= 1'b0;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_reg <= FAULT;
                            fault_o   <= 1'b1;
                        end else begin
                            state_reg       <= HOLDOFF;
                            holdoff_cnt_reg <= '0;
                        end
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
                end
                MONITOR: begin
                    if (!link_ready_i) begin
                        state_reg <= IDLE;
                        enable_o  <= 1'b0;
                        aligned_o <= 1'b0;
                    end else if (!locked_i || (faw_bad && bad_inc == BAD_LIMIT)) begin
                        // Lock loss and a final bad FAW in the same cycle count as one realign.
                        state_reg       <= HOLDOFF;
                        holdoff_cnt_reg <= '0;
                        enable_o        <= 1'b0;
                        aligned_o       <= 1'b0;
                        if (realign_count_o != 8'hFF) begin
                            realign_count_o <= realign_count_o + 8'd1;
                        end
                    end else if (faw_boundary_i) begin
                        bad_cnt_reg <= faw_bad ? bad_inc : 4'd0;
                    end
                end
                FAULT: begin
                    if (clear_fault_i) begin
                        state_reg     <= IDLE;
                        fault_o       <= 1'b0;
                        retry_count_o <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    enable_o  <= 1'b0;
                    aligned_o <= 1'b0;
                    fault_o   <= 1'b0;
                end
            endcase
        end
    end

`ifdef QECIPHY_RX_ALIGN_STATS_EN
    // Lifetime tally of bad FAWs seen while monitoring; only rst_i clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bad_faw_total_o <= '0;
        end else if (state_reg == MONITOR && link_ready_i && faw_bad && bad_faw_total_o != 16'hFFFF) begin
            bad_faw_total_o <= bad_faw_total_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qeciphy_rx_align_ctrl.sv
// Directed self-checking bench for qeciphy_rx_align_ctrl (LOCK_TIMEOUT=64, MAX_RETRIES=3).
// Stats checks are compiled in when QECIPHY_RX_ALIGN_STATS_EN is defined.

module tb_qeciphy_rx_align_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        link_ready_i;
    logic        clear_fault_i;
    logic [63:0] tdata_i;
    logic        locked_i;
    logic        faw_boundary_i;
    logic        enable_o;
    logic        aligned_o;
    logic        fault_o;
    logic [3:0]  retry_count_o;
    logic [7:0]  realign_count_o;
`ifdef QECIPHY_RX_ALIGN_STATS_EN
    logic [15:0] bad_faw_total_o;
`endif

    localparam logic [63:0] GOOD_WORD = 64'hF628_F628_F628_F628;
    localparam logic [63:0] BAD_WORD  = 64'h0123_4567_89AB_CDEF;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    qeciphy_rx_align_ctrl #(
        .LOCK_TIMEOUT  (64),
        .BAD_FAW_LIMIT (4),
        .HOLDOFF_CYCLES(16),
        .MAX_RETRIES   (3)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .link_ready_i   (link_ready_i),
        .clear_fault_i  (clear_fault_i),
        .tdata_i        (tdata_i),
        .locked_i       (locked_i),
        .faw_boundary_i (faw_boundary_i),
        .enable_o       (enable_o),
        .aligned_o      (aligned_o),
        .fault_o        (fault_o),
        .retry_count_o  (retry_count_o),
        .realign_count_o(realign_count_o)
`ifdef QECIPHY_RX_ALIGN_STATS_EN
        ,
        .bad_faw_total_o(bad_faw_total_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end else begin
            $display("[TB] ok   %s: %0d", tag, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic boundary(input bit good);
        faw_boundary_i = 1'b1;
        tdata_i        = good ? GOOD_WORD : BAD_WORD;
        tick();
        faw_boundary_i = 1'b0;
        tdata_i        = BAD_WORD;
    endtask

    initial begin
        rst_i          = 1'b1;
        link_ready_i   = 1'b0;
        clear_fault_i  = 1'b0;
        tdata_i        = BAD_WORD;
        locked_i       = 1'b0;
        faw_boundary_i = 1'b0;
        ticks(2);
        check("rst_enable", 32'(enable_o), 0);
        check("rst_aligned", 32'(aligned_o), 0);
        check("rst_fault", 32'(fault_o), 0);
        check("rst_retry", 32'(retry_count_o), 0);
        check("rst_realign", 32'(realign_count_o), 0);

        // Bring-up: IDLE -> HOLDOFF, 16 holdoff cycles, then search and lock after 40 cycles.
        rst_i        = 1'b0;
        link_ready_i = 1'b1;
        tick();
        check("holdoff_entry_enable", 32'(enable_o), 0);
        ticks(15);
        check("holdoff_15_enable", 32'(enable_o), 0);
        tick();
        check("holdoff_16_enable", 32'(enable_o), 1);
        ticks(40);
        check("search_aligned", 32'(aligned_o), 0);
        check("search_enable", 32'(enable_o), 1);
        locked_i = 1'b1;
        tick();
        check("lock_aligned", 32'(aligned_o), 1);
        check("lock_retry", 32'(retry_count_o), 0);

        clear_fault_i = 1'b1;
        tick();
        clear_fault_i = 1'b0;
        check("clear_outside_fault_fault", 32'(fault_o), 0);
        check("clear_outside_fault_aligned", 32'(aligned_o), 1);

        // 3 bad, 1 good, 3 bad: the good FAW resets the run, so no realign.
        for (int i = 0; i < 3; i++) boundary(1'b0);
        boundary(1'b1);
        for (int i = 0; i < 3; i++) boundary(1'b0);
        check("interleaved_enable", 32'(enable_o), 1);
        check("interleaved_realign", 32'(realign_count_o), 0);
        check("interleaved_aligned", 32'(aligned_o), 1);

        // One good to clear the run of three, then four bad in a row.
        boundary(1'b1);
        for (int i = 0; i < 3; i++) boundary(1'b0);
        check("bad3_enable", 32'(enable_o), 1);
        boundary(1'b0);
        check("bad4_enable", 32'(enable_o), 0);
        check("bad4_realign", 32'(realign_count_o), 1);
        check("bad4_aligned", 32'(aligned_o), 0);
        ticks(15);
        check("realign_holdoff_15", 32'(enable_o), 0);
        tick();
        check("realign_holdoff_16", 32'(enable_o), 1);
        tick();
        check("relock_aligned", 32'(aligned_o), 1);

        // Link drop in MONITOR.
        link_ready_i = 1'b0;
        tick();
        check("linkdrop_enable", 32'(enable_o), 0);
        check("linkdrop_aligned", 32'(aligned_o), 0);
        check("linkdrop_realign", 32'(realign_count_o), 1);

        // Three lock timeouts -> FAULT.
        locked_i     = 1'b0;
        link_ready_i = 1'b1;
        tick();
        for (int r = 1; r <= 3; r++) begin
            ticks(16);
            check($sformatf("timeout%0d_search_enable", r), 32'(enable_o), 1);
            ticks(63);
            check($sformatf("timeout%0d_before_retry", r), 32'(retry_count_o), 32'(r - 1));
            tick();
            check($sformatf("timeout%0d_retry", r), 32'(retry_count_o), 32'(r));
            check($sformatf("timeout%0d_fault", r), 32'(fault_o), (r == 3) ? 32'd1 : 32'd0);
            check($sformatf("timeout%0d_enable", r), 32'(enable_o), 0);
        end
        link_ready_i = 1'b0;
        tick();
        check("fault_ignores_link", 32'(fault_o), 1);
        link_ready_i  = 1'b1;
        clear_fault_i = 1'b1;
        tick();
        clear_fault_i = 1'b0;
        check("clear_fault_fault", 32'(fault_o), 0);
        check("clear_fault_retry", 32'(retry_count_o), 0);
        check("clear_fault_realign", 32'(realign_count_o), 1);
        check("clear_fault_enable", 32'(enable_o), 0);

        // One timeout, then lock arriving on the terminal cycle wins and clears retries.
        tick();
        ticks(16);
        ticks(64);
        check("post_clear_retry", 32'(retry_count_o), 1);
        ticks(16);
        ticks(63);
        locked_i = 1'b1;
        tick();
        check("terminal_lock_retry", 32'(retry_count_o), 0);
        check("terminal_lock_aligned", 32'(aligned_o), 1);
        check("terminal_lock_fault", 32'(fault_o), 0);

        // Lock loss together with a bad FAW counts a single realign.
        locked_i = 1'b0;
        boundary(1'b0);
        check("dual_event_realign", 32'(realign_count_o), 2);
        check("dual_event_enable", 32'(enable_o), 0);

        // Asynchronous reset in the middle of SEARCH.
        ticks(16);
        ticks(5);
        check("pre_async_enable", 32'(enable_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_enable", 32'(enable_o), 0);
        check("async_rst_realign", 32'(realign_count_o), 0);
        tick();
        rst_i = 1'b0;
        tick();
        check("post_rst_enable", 32'(enable_o), 0);

        // 300 realigns of four bad FAWs each: realign counter saturates at 255.
        locked_i = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            ticks(16);
            tick();
            for (int b = 0; b < 4; b++) boundary(1'b0);
            if (i == 255) check("sat_realign_255", 32'(realign_count_o), 255);
        end
        check("sat_realign_300", 32'(realign_count_o), 255);
        check("sat_enable", 32'(enable_o), 0);
`ifdef QECIPHY_RX_ALIGN_STATS_EN
        check("stats_bad_faw_total", 32'(bad_faw_total_o), 1200);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
